fc_layer_sequencer: RTL and testbench
=====================================

FC_LAYER_SEQUENCER -- requirements
Module: fc_layer_sequencer

Interface
REQ-001 Parameter INPUT_SIZE, default 512, activations per input vector.
REQ-002 Parameter OUTPUT_SIZE, default 128, neurons per layer.
REQ-003 Parameter ACTIV_BITS, default 8, width of weights, biases, activations and outputs (signed two's complement).
REQ-004 Port clk input 1: the single clock; all logic on rising edge.
REQ-005 Port rst input 1: asynchronous, active-high reset.
REQ-006 Port start input 1: begin a layer pass; sampled only in IDLE.
REQ-007 Port abort input 1: synchronous cancel of an in-progress pass.
REQ-008 Port busy output 1: high in every state except IDLE.
REQ-009 Port done output 1: one-cycle pulse after the last neuron is accepted.
REQ-010 Port rd_en output 1: read strobe shared by weight, input and bias memories.
REQ-011 Port in_addr output clog2(INPUT_SIZE): activation buffer address.
REQ-012 Port in_data input ACTIV_BITS: activation read data, valid one cycle after rd_en.
REQ-013 Port w_addr output clog2(OUTPUT_SIZE*INPUT_SIZE): weight address, row-major (neuron*INPUT_SIZE+input).
REQ-014 Port w_data input ACTIV_BITS: weight read data, one-cycle latency.
REQ-015 Port b_addr output clog2(OUTPUT_SIZE): bias address.
REQ-016 Port b_data input ACTIV_BITS: bias read data, one-cycle latency.
REQ-017 Port out_valid output 1, out_ready input 1, out_idx output clog2(OUTPUT_SIZE), out_data output ACTIV_BITS: result stream, one neuron per transfer.

Function
REQ-018 FSM states IDLE, BIAS, MAC, DRAIN, EMIT, DONE; one neuron index i and one input index k counter.
REQ-019 IDLE: start=1 -> BIAS with i=0; start in any other state ignored.
REQ-020 BIAS (1 cycle): rd_en=1, b_addr=i -> MAC with k=0.
REQ-021 MAC (INPUT_SIZE cycles): rd_en=1, in_addr=k, w_addr=i*INPUT_SIZE+k; at k=0 accumulator loads sign-extended b_data, at k>0 adds w_data*in_data of k-1; after k=INPUT_SIZE-1 -> DRAIN.
REQ-022 DRAIN (1 cycle): rd_en=0; adds last product -> EMIT.
REQ-023 Accumulator width 2*ACTIV_BITS+clog2(INPUT_SIZE)+1, signed; no intermediate overflow possible.
REQ-024 EMIT: out_valid=1, out_idx=i, out_data=saturated activation of accumulator, all stable until out_ready; on out_valid&&out_ready: i==OUTPUT_SIZE-1 -> DONE, else i+1 -> BIAS.
REQ-025 Saturation clamps to [-2^(ACTIV_BITS-1), 2^(ACTIV_BITS-1)-1].
REQ-026 DONE (1 cycle): done=1 -> IDLE.
REQ-027 Minimum latency start to done: OUTPUT_SIZE*(INPUT_SIZE+3)+1 cycles with out_ready held high.
REQ-028 abort=1 in any non-IDLE state -> IDLE next cycle; no done, out_valid dropped, rd_en=0; abort has priority over out_ready in the same cycle.
REQ-029 rd_en=0 in IDLE, DRAIN, EMIT, DONE; address outputs then hold their last value.

Reset
REQ-030 rst=1 forces IDLE immediately; busy, done, rd_en, out_valid=0; i, k, accumulator, all address outputs, out_idx, out_data=0.
REQ-031 Reset mid-pass discards the pass; first cycle after release is IDLE.

Configuration
REQ-032 Macro FC_SEQ_RELU_EN defined: negative accumulator emits 0 before saturation; not defined: signed saturated value emitted unchanged.

Structure
REQ-033 Shared package fc_pkg holds the FSM state enum and the accumulator-width and saturation constant functions.
REQ-034 One sub-module fc_mac: signed multiply-accumulate with load, add and saturating/ReLU output.

Verification (INPUT_SIZE=4, OUTPUT_SIZE=2, ACTIV_BITS=8)
REQ-035 Weights all 1, inputs 1,2,3,4, biases 0,5, out_ready=1 -> outputs (idx0,10),(idx1,15); done at cycle 15 after start.
REQ-036 Weights 127, inputs 127, bias 127 -> out_data=127 (saturated).
REQ-037 Weights -1, inputs 10, bias 0 -> out_data=0 with FC_SEQ_RELU_EN, -40 without.
REQ-038 out_ready low 5 cycles in EMIT -> out_valid, out_idx, out_data stable; pass completes 5 cycles late.
REQ-039 abort in MAC at k=2 -> busy=0 next cycle, no done; new start produces correct results.
REQ-040 rst asserted in EMIT -> all outputs 0 immediately; start after release ignored? no: accepted and runs full pass.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer sequencer:
// FSM state encoding, address/accumulator width helpers and
// saturation bounds for the signed activation format.
package fc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIAS,
        S_MAC,
        S_DRAIN,
        S_EMIT,
        S_DONE
    } fc_state_e;

    // Address width for a memory of 'depth' entries (at least one bit).
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Accumulator wide enough that INPUT_SIZE full-scale products plus a
    // bias can never overflow.
    function automatic int acc_width(input int activ_bits, input int input_size);
        return 2 * activ_bits + addr_width(input_size) + 1;
    endfunction

    function automatic int sat_max(input int activ_bits);
        return (1 << (activ_bits - 1)) - 1;
    endfunction

    function automatic int sat_min(input int activ_bits);
        return -(1 << (activ_bits - 1));
    endfunction

endpackage

// File: rtl/fc_layer_sequencer_if.sv
// Memory read bus (weights, activations, biases) and result stream of the
// layer sequencer. master = sequencer side, slave = memories/result sink.
interface fc_layer_sequencer_if #(
    parameter int INPUT_SIZE  = 512,
    parameter int OUTPUT_SIZE = 128,
    parameter int ACTIV_BITS  = 8
);
    localparam int IN_AW = fc_pkg::addr_width(INPUT_SIZE);
    localparam int W_AW  = fc_pkg::addr_width(OUTPUT_SIZE * INPUT_SIZE);
    localparam int B_AW  = fc_pkg::addr_width(OUTPUT_SIZE);

    logic                         rd_en;
    logic        [IN_AW-1:0]      in_addr;
    logic signed [ACTIV_BITS-1:0] in_data;
    logic        [W_AW-1:0]       w_addr;
    logic signed [ACTIV_BITS-1:0] w_data;
    logic        [B_AW-1:0]       b_addr;
    logic signed [ACTIV_BITS-1:0] b_data;

    logic                         out_valid;
    logic                         out_ready;
    logic        [B_AW-1:0]       out_idx;
    logic signed [ACTIV_BITS-1:0] out_data;

    modport master (
        output rd_en, in_addr, w_addr, b_addr,
        input  in_data, w_data, b_data,
        output out_valid, out_idx, out_data,
        input  out_ready
    );

    modport slave (
        input  rd_en, in_addr, w_addr, b_addr,
        output in_data, w_data, b_data,
        input  out_valid, out_idx, out_data,
        output out_ready
    );

endinterface

// File: rtl/fc_mac.sv
// Signed multiply-accumulate for one neuron: load bias, add weight*activation
// products, present the clamped (and optionally rectified) activation.
// Optional feature: define FC_SEQ_RELU_EN to emit 0 for negative sums.
module fc_mac
    import fc_pkg::*;
#(
    parameter int ACTIV_BITS = 8,
    parameter int ACC_W      = acc_width(8, 512)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic                         add,
    input  logic signed [ACTIV_BITS-1:0] bias,
    input  logic signed [ACTIV_BITS-1:0] weight,
    input  logic signed [ACTIV_BITS-1:0] act,
    output logic signed [ACTIV_BITS-1:0] result
);

    localparam int PW = 2 * ACTIV_BITS;
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACTIV_BITS));
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACTIV_BITS));

    logic signed [PW-1:0]    product;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_clip;

    assign product = weight * act;

    // Accumulator: bias load starts a neuron, each valid product is added.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (load) begin
            acc <= {{(ACC_W - ACTIV_BITS){bias[ACTIV_BITS-1]}}, bias};
        end else if (add) begin
            acc <= acc + {{(ACC_W - PW){product[PW-1]}}, product};
        end
    end

    // Output stage: optional rectification, then clamp to the activation range.
    // NOTE: acc_clip gets its default before any conditional so no latch forms.
    always_comb begin
        acc_clip = acc;
`ifdef FC_SEQ_RELU_EN
        if (acc[ACC_W-1]) begin
            acc_clip = '0;
        end
`else
`endif
        if (acc_clip > ACC_MAX) begin
            acc_clip = ACC_MAX;
        end else if (acc_clip < ACC_MIN) begin
            acc_clip = ACC_MIN;
        end
    end

    assign result = acc_clip[ACTIV_BITS-1:0];

endmodule

// File: rtl/fc_layer_sequencer.sv
// Fully-connected layer sequencer: for each neuron reads the bias, streams
// INPUT_SIZE weight/activation pairs through fc_mac, then emits the result.
// Optional feature (in fc_mac): FC_SEQ_RELU_EN selects ReLU before clamping.
module fc_layer_sequencer
    import fc_pkg::*;
#(
    parameter int INPUT_SIZE  = 512,
    parameter int OUTPUT_SIZE = 128,
    parameter int ACTIV_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    fc_layer_sequencer_if.master  bus
);

    localparam int IW    = addr_width(OUTPUT_SIZE);
    localparam int KW    = addr_width(INPUT_SIZE);
    localparam int WW    = addr_width(OUTPUT_SIZE * INPUT_SIZE);
    localparam int ACC_W = acc_width(ACTIV_BITS, INPUT_SIZE);

    fc_state_e       state, state_n;
    logic [IW-1:0]   i_q, i_n;
    logic [KW-1:0]   k_q, k_n;
    logic            mac_load;
    logic            mac_add;

    // State and neuron/input counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            i_q   <= '0;
            k_q   <= '0;
        end else begin
            state <= state_n;
            i_q   <= i_n;
            k_q   <= k_n;
        end
    end

    // Next-state, counter updates and control strobes; abort overrides all.
    always_comb begin
        state_n       = state;
        i_n           = i_q;
        k_n           = k_q;
        bus.rd_en     = 1'b0;
        bus.out_valid = 1'b0;
        done          = 1'b0;
        mac_load      = 1'b0;
        mac_add       = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_BIAS;
                    i_n     = '0;
                    k_n     = '0;
                end
            end
            S_BIAS: begin
                bus.rd_en = 1'b1;
                state_n   = S_MAC;
            end
            S_MAC: begin
                bus.rd_en = 1'b1;
                // Read data seen here belongs to the previous cycle's address:
                // bias at k=0, product k-1 afterwards.
                if (k_q == '0) begin
                    mac_load = 1'b1;
                end else begin
                    mac_add = 1'b1;
                end
                if (k_q == KW'(INPUT_SIZE - 1)) begin
                    state_n = S_DRAIN;
                end else begin
                    k_n = k_q + 1'b1;
                end
            end
            S_DRAIN: begin
                mac_add = 1'b1;
                state_n = S_EMIT;
            end
            S_EMIT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    if (i_q == IW'(OUTPUT_SIZE - 1)) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_BIAS;
                        i_n     = i_q + 1'b1;
                        k_n     = '0;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (abort && (state != S_IDLE)) begin
            state_n       = S_IDLE;
            i_n           = i_q;
            k_n           = k_q;
            bus.rd_en     = 1'b0;
            bus.out_valid = 1'b0;
            done          = 1'b0;
            mac_load      = 1'b0;
            mac_add       = 1'b0;
        end
    end

    assign busy = (state != S_IDLE);

    // Addresses follow the counters, which only move while reading (or when
    // entering BIAS), so they hold their last value whenever rd_en is low.
    assign bus.in_addr = k_q;
    assign bus.b_addr  = i_q;
    assign bus.out_idx = i_q;
    assign bus.w_addr  = WW'(i_q) * WW'(INPUT_SIZE) + WW'(k_q);

    fc_mac #(
        .ACTIV_BITS (ACTIV_BITS),
        .ACC_W      (ACC_W)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .load   (mac_load),
        .add    (mac_add),
        .bias   (bus.b_data),
        .weight (bus.w_data),
        .act    (bus.in_data),
        .result (bus.out_data)
    );

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Bench for fc_layer_sequencer with INPUT_SIZE=4, OUTPUT_SIZE=2, ACTIV_BITS=8.
// Vector table of memory images with hand-computed neuron results, plus
// directed sequences for back-pressure, abort and reset during EMIT.
module tb_fc_layer_sequencer;

    localparam int IN_SZ  = 4;
    localparam int OUT_SZ = 2;
    localparam int AB     = 8;
    localparam int NVEC   = 8;

    typedef struct {
        int w[8];
        int x[4];
        int b[2];
        int e[2];   // expected without ReLU
        int er[2];  // expected with ReLU
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy;
    logic done;

    int checks = 0;
    int errors = 0;

    vec_t vecs[NVEC];

    logic signed [AB-1:0] wmem [8];
    logic signed [AB-1:0] xmem [4];
    logic signed [AB-1:0] bmem [2];

    fc_layer_sequencer_if #(.INPUT_SIZE(IN_SZ), .OUTPUT_SIZE(OUT_SZ), .ACTIV_BITS(AB)) bus ();

    fc_layer_sequencer #(
        .INPUT_SIZE  (IN_SZ),
        .OUTPUT_SIZE (OUT_SZ),
        .ACTIV_BITS  (AB)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories with one cycle of latency.
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.in_data <= xmem[bus.in_addr];
            bus.w_data  <= wmem[bus.w_addr];
            bus.b_data  <= bmem[bus.b_addr];
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int expected(input int v, input int n);
`ifdef FC_SEQ_RELU_EN
        return vecs[v].er[n];
`else
        return vecs[v].e[n];
`endif
    endfunction

    task automatic load_vec(input int v);
        for (int j = 0; j < 8; j++) wmem[j] = 8'(vecs[v].w[j]);
        for (int j = 0; j < 4; j++) xmem[j] = 8'(vecs[v].x[j]);
        for (int j = 0; j < 2; j++) bmem[j] = 8'(vecs[v].b[j]);
    endtask

    // Full pass with out_ready high; start is held for three cycles to show
    // it is ignored outside IDLE. cnt = cycles since the start edge.
    task automatic run_pass(input int v, input int exp_lat);
        int cnt;
        int n;
        bit seen_done;
        load_vec(v);
        bus.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        cnt = 0;
        n = 0;
        seen_done = 1'b0;
        while (!seen_done && cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt >= 3) start = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                if (n < 2) begin
                    check($sformatf("v%0d_idx%0d", v, n), int'(bus.out_idx), n);
                    check($sformatf("v%0d_data%0d", v, n), int'(bus.out_data), expected(v, n));
                end
                n++;
            end
            if (done) seen_done = 1'b1;
        end
        start = 1'b0;
        check($sformatf("v%0d_done_latency", v), cnt, exp_lat);
        check($sformatf("v%0d_out_count", v), n, 2);
        @(posedge clk);
        #1;
        check($sformatf("v%0d_idle_after_done", v), int'(busy), 0);
    endtask

    // Waits for EMIT of neuron 0 with out_ready low; returns cycles since start.
    task automatic start_to_emit(input int v, output int cnt);
        load_vec(v);
        bus.out_ready = 1'b0;
        @(negedge clk);
        start = 1'b1;
        cnt = 0;
        while (!bus.out_valid && cnt < 50) begin
            @(posedge clk);
            #1;
            cnt++;
            start = 1'b0;
        end
        start = 1'b0;
    endtask

    initial begin
        int cnt;
        int n;
        bit seen_done;
        bit bad;

        // Vector table: weights row-major (neuron0 k0..3, neuron1 k0..3).
        vecs[0].w = '{1, 1, 1, 1, 1, 1, 1, 1};  vecs[0].x = '{1, 2, 3, 4};
        vecs[0].b = '{0, 5};  vecs[0].e = '{10, 15};  vecs[0].er = '{10, 15};
        vecs[1].w = '{127, 127, 127, 127, 127, 127, 127, 127};  vecs[1].x = '{127, 127, 127, 127};
        vecs[1].b = '{127, 127};  vecs[1].e = '{127, 127};  vecs[1].er = '{127, 127};
        vecs[2].w = '{-1, -1, -1, -1, -1, -1, -1, -1};  vecs[2].x = '{10, 10, 10, 10};
        vecs[2].b = '{0, 0};  vecs[2].e = '{-40, -40};  vecs[2].er = '{0, 0};
        vecs[3].w = '{1, -2, 3, -4, 2, 2, 2, 2};  vecs[3].x = '{5, 6, 7, 8};
        vecs[3].b = '{3, -1};  vecs[3].e = '{-15, 51};  vecs[3].er = '{0, 51};
        vecs[4].w = '{-128, -128, -128, -128, -128, -128, -128, -128};  vecs[4].x = '{127, 127, 127, 127};
        vecs[4].b = '{-128, 0};  vecs[4].e = '{-128, -128};  vecs[4].er = '{0, 0};
        vecs[5].w = '{0, 0, 0, 1, 1, 0, 0, 0};  vecs[5].x = '{9, 8, 7, 6};
        vecs[5].b = '{0, 0};  vecs[5].e = '{6, 9};  vecs[5].er = '{6, 9};
        vecs[6].w = '{1, 1, 1, 1, 1, 1, 1, 1};  vecs[6].x = '{32, 32, 32, 32};
        vecs[6].b = '{0, -1};  vecs[6].e = '{127, 127};  vecs[6].er = '{127, 127};
        vecs[7].w = '{0, 0, 0, 0, 0, 0, 0, 0};  vecs[7].x = '{1, 1, 1, 1};
        vecs[7].b = '{127, -128};  vecs[7].e = '{127, -128};  vecs[7].er = '{127, 0};

        for (int j = 0; j < 8; j++) wmem[j] = '0;
        for (int j = 0; j < 4; j++) xmem[j] = '0;
        for (int j = 0; j < 2; j++) bmem[j] = '0;
        bus.in_data   = '0;
        bus.w_data    = '0;
        bus.b_data    = '0;
        bus.out_ready = 1'b0;

        // Reset state.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rd_en", int'(bus.rd_en), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_in_addr", int'(bus.in_addr), 0);
        check("rst_w_addr", int'(bus.w_addr), 0);
        check("rst_b_addr", int'(bus.b_addr), 0);
        check("rst_out_idx", int'(bus.out_idx), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven passes: 7 cycles per neuron plus DONE.
        for (int v = 0; v < NVEC; v++) begin
            run_pass(v, OUT_SZ * (IN_SZ + 3) + 1);
        end

        // Back-pressure: out_ready low for 5 cycles in EMIT of neuron 0.
        start_to_emit(0, cnt);
        check("bp_emit_cycle", cnt, 7);
        for (int s = 0; s < 5; s++) begin
            check("bp_hold_valid", int'(bus.out_valid), 1);
            check("bp_hold_idx", int'(bus.out_idx), 0);
            check("bp_hold_data", int'(bus.out_data), 10);
            @(posedge clk);
            #1;
            cnt++;
        end
        bus.out_ready = 1'b1;
        check("bp_release_valid", int'(bus.out_valid), 1);
        check("bp_release_data", int'(bus.out_data), 10);
        n = 0;
        seen_done = 1'b0;
        while (!seen_done && cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
            if (bus.out_valid && bus.out_ready) begin
                check("bp_n1_idx", int'(bus.out_idx), 1);
                check("bp_n1_data", int'(bus.out_data), 15);
                n++;
            end
            if (done) seen_done = 1'b1;
        end
        check("bp_done_latency", cnt, 20);
        check("bp_n1_count", n, 1);
        @(negedge clk);

        // Abort in MAC at k=2 (cycle 4 after start).
        load_vec(3);
        bus.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check("abort_at_k2_in_addr", int'(bus.in_addr), 2);
        check("abort_at_k2_busy", int'(busy), 1);
        abort = 1'b1;
        #1;
        check("abort_rd_en_dropped", int'(bus.rd_en), 0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy_next", int'(busy), 0);
        bad = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done || bus.out_valid || busy) bad = 1'b1;
        end
        check("abort_no_activity", int'(bad), 0);
        run_pass(5, OUT_SZ * (IN_SZ + 3) + 1);

        // Reset while in EMIT: outputs clear at once, next start runs fully.
        start_to_emit(0, cnt);
        check("rst_emit_cycle", cnt, 7);
        check("rst_emit_data_before", int'(bus.out_data), 10);
        rst = 1'b1;
        #1;
        check("rst_emit_busy", int'(busy), 0);
        check("rst_emit_out_valid", int'(bus.out_valid), 0);
        check("rst_emit_rd_en", int'(bus.rd_en), 0);
        check("rst_emit_out_data", int'(bus.out_data), 0);
        check("rst_emit_out_idx", int'(bus.out_idx), 0);
        check("rst_emit_w_addr", int'(bus.w_addr), 0);
        check("rst_emit_in_addr", int'(bus.in_addr), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_release_idle", int'(busy), 0);
        run_pass(3, OUT_SZ * (IN_SZ + 3) + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
